// File: rtl/cell_pair_scheduler.sv
// Phase-1 cell-pair sequencer: sweeps every home cell of the 3-D grid and issues it with
// its 13 half-shell neighbours (periodic wrap), throttled by an in-flight pair count.
module cell_pair_scheduler #(
    parameter int CELLS_X      = 4,
    parameter int CELLS_Y      = 4,
    parameter int CELLS_Z      = 4,
    parameter int CID_W        = 2,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 phase1_ready,
    output logic                 pair_valid,
    input  logic                 pair_ready,
    output logic [3*CID_W-1:0]   home_cell,
    output logic [3*CID_W-1:0]   nbr_cell,
    output logic [3:0]           nbr_idx,
    input  logic                 pair_done,
    output logic                 phase1_done,
    output logic                 busy,
    output logic                 err
);
    localparam int IF_W = $clog2(MAX_INFLIGHT + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_DRAIN    = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_WAIT_LOW = 3'd4;

    localparam logic [3:0] LAST_IDX = 4'd13;

    // Per-axis offset codes: 0, +1, -1
    localparam logic [1:0] DZR = 2'b00;
    localparam logic [1:0] DP  = 2'b01;
    localparam logic [1:0] DM  = 2'b11;

    // Axis 0 = x, 1 = y, 2 = z
    localparam logic [2:0][CID_W-1:0] MAX_AX = {CID_W'(CELLS_Z - 1),
                                                CID_W'(CELLS_Y - 1),
                                                CID_W'(CELLS_X - 1)};

    logic [2:0]              state_q, state_d;
    logic [2:0][CID_W-1:0]   home_q, home_d;
    logic [3:0]              idx_q, idx_d;
    logic [IF_W-1:0]         inflight_q, inflight_d;
    logic                    err_q, err_d;

    logic [2:0][1:0]         d_ax;
    logic [2:0][CID_W-1:0]   nbr_ax;
    logic [2:0][CID_W-1:0]   home_step;
    logic [2:0]              at_max;
    logic [2:0]              carry;
    logic                    xfer;
    logic                    last_pair;

    // Offsets packed as {dz, dy, dx}
    always_comb begin
        d_ax = {DZR, DZR, DZR};
        case (idx_q)
            4'd1:    d_ax = {DZR, DZR, DP };
            4'd2:    d_ax = {DZR, DP,  DM };
            4'd3:    d_ax = {DZR, DP,  DZR};
            4'd4:    d_ax = {DZR, DP,  DP };
            4'd5:    d_ax = {DP,  DM,  DM };
            4'd6:    d_ax = {DP,  DM,  DZR};
            4'd7:    d_ax = {DP,  DM,  DP };
            4'd8:    d_ax = {DP,  DZR, DM };
            4'd9:    d_ax = {DP,  DZR, DZR};
            4'd10:   d_ax = {DP,  DZR, DP };
            4'd11:   d_ax = {DP,  DP,  DM };
            4'd12:   d_ax = {DP,  DP,  DZR};
            4'd13:   d_ax = {DP,  DP,  DP };
            default: d_ax = {DZR, DZR, DZR};
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_axis
            assign at_max[gi] = (home_q[gi] == MAX_AX[gi]);

            assign nbr_ax[gi] = (d_ax[gi] == DP) ? (at_max[gi] ? '0 : home_q[gi] + CID_W'(1)) :
                                (d_ax[gi] == DM) ? ((home_q[gi] == '0) ? MAX_AX[gi]
                                                                       : home_q[gi] - CID_W'(1)) :
                                home_q[gi];

            // x steps every cell; y and z step only when all lower axes roll over
            if (gi == 0) begin : g_c0
                assign carry[gi] = 1'b1;
            end else begin : g_cn
                assign carry[gi] = carry[gi-1] & at_max[gi-1];
            end

            assign home_step[gi] = carry[gi] ? (at_max[gi] ? '0 : home_q[gi] + CID_W'(1))
                                             : home_q[gi];
        end
    endgenerate

    assign pair_valid  = (state_q == S_ISSUE) && (inflight_q < IF_W'(MAX_INFLIGHT));
    assign xfer        = pair_valid && pair_ready;
    assign last_pair   = (idx_q == LAST_IDX) && (&at_max);
    assign home_cell   = home_q;
    assign nbr_cell    = nbr_ax;
    assign nbr_idx     = idx_q;
    assign phase1_done = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign err         = err_q;

    always_comb begin
        state_d = state_q;
        home_d  = home_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (phase1_ready) begin
                    state_d = S_ISSUE;
                    home_d  = '0;
                    idx_d   = '0;
                end
            end
            S_ISSUE: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d  = '0;
                        home_d = home_step;
                        if (last_pair) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:     state_d = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (!phase1_ready) begin
                    state_d = S_IDLE;
                end
            end
            default:    state_d = S_IDLE;
        endcase
    end

    // A pair_done with nothing outstanding is flagged and otherwise ignored
    always_comb begin
        inflight_d = inflight_q;
        err_d      = err_q;
        if (pair_done && (inflight_q == '0)) begin
            err_d = 1'b1;
            if (xfer) begin
                inflight_d = inflight_q + IF_W'(1);
            end
        end else if (xfer && !pair_done) begin
            inflight_d = inflight_q + IF_W'(1);
        end else if (!xfer && pair_done) begin
            inflight_d = inflight_q - IF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            home_q     <= '0;
            idx_q      <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            home_q     <= home_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_cell_pair_scheduler.sv
// Directed bench: a 3x3x3 instance for reset and the full sweep, a 4x4x4 instance for
// wrap, backpressure, throttling, abort and the error flag.
module tb_cell_pair_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int dx_t[14] = '{0, 1, -1, 0, 1, -1, 0, 1, -1, 0, 1, -1, 0, 1};
    int dy_t[14] = '{0, 0, 1, 1, 1, -1, -1, -1, 0, 0, 0, 1, 1, 1};
    int dz_t[14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

    // Instance A: 3x3x3
    logic       a_reset, a_phase1_ready, a_pair_ready, a_pair_done;
    logic       a_pair_valid, a_phase1_done, a_busy, a_err;
    logic [5:0] a_home_cell, a_nbr_cell;
    logic [3:0] a_nbr_idx;
    logic [15:0] a_pair;
    assign a_pair = {a_home_cell, a_nbr_cell, a_nbr_idx};

    // Instance B: 4x4x4
    logic       b_reset, b_phase1_ready, b_pair_ready, b_pair_done;
    logic       b_pair_valid, b_phase1_done, b_busy, b_err;
    logic [5:0] b_home_cell, b_nbr_cell;
    logic [3:0] b_nbr_idx;
    logic [15:0] b_pair;
    assign b_pair = {b_home_cell, b_nbr_cell, b_nbr_idx};

    cell_pair_scheduler #(.CELLS_X(3), .CELLS_Y(3), .CELLS_Z(3), .CID_W(2), .MAX_INFLIGHT(8)) dut_a (
        .clk(clk), .reset(a_reset), .phase1_ready(a_phase1_ready),
        .pair_valid(a_pair_valid), .pair_ready(a_pair_ready),
        .home_cell(a_home_cell), .nbr_cell(a_nbr_cell), .nbr_idx(a_nbr_idx),
        .pair_done(a_pair_done), .phase1_done(a_phase1_done), .busy(a_busy), .err(a_err)
    );

    cell_pair_scheduler #(.CELLS_X(4), .CELLS_Y(4), .CELLS_Z(4), .CID_W(2), .MAX_INFLIGHT(8)) dut_b (
        .clk(clk), .reset(b_reset), .phase1_ready(b_phase1_ready),
        .pair_valid(b_pair_valid), .pair_ready(b_pair_ready),
        .home_cell(b_home_cell), .nbr_cell(b_nbr_cell), .nbr_idx(b_nbr_idx),
        .pair_done(b_pair_done), .phase1_done(b_phase1_done), .busy(b_busy), .err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {home, nbr, idx} of the n-th pair in sweep order
    function automatic logic [15:0] exp_pair(input int n, input int cx, input int cy, input int cz);
        int idx, c, x, y, z, nx, ny, nz;
        idx = n % 14;
        c   = n / 14;
        x   = c % cx;
        y   = (c / cx) % cy;
        z   = c / (cx * cy);
        nx  = (x + dx_t[idx] + cx) % cx;
        ny  = (y + dy_t[idx] + cy) % cy;
        nz  = (z + dz_t[idx] + cz) % cz;
        return {2'(z), 2'(y), 2'(x), 2'(nz), 2'(ny), 2'(nx), 4'(idx)};
    endfunction

    int b_xfers   = 0;
    int b_inflt   = 0;

    // Runs B with pair_ready=1, completing one outstanding pair per cycle, until target transfers
    task automatic run_b(input int target);
        int  cyc;
        logic xf;
        cyc = 0;
        b_pair_ready = 1'b1;
        while (b_xfers < target && cyc < target * 3 + 50) begin
            xf = b_pair_valid && b_pair_ready;
            if (xf) begin
                check("run_pair", b_pair, exp_pair(b_xfers, 4, 4, 4));
                if (b_xfers == 43)  check("wrap_pos_x", b_nbr_cell, 6'b00_00_00);
                if (b_xfers == 2)   check("wrap_neg_x", b_nbr_cell, 6'b00_01_11);
                if (b_xfers == 677) check("wrap_z",     b_nbr_cell, 6'b00_11_11);
                b_xfers++;
            end
            b_pair_done = (b_inflt > 0);
            b_inflt = b_inflt + (xf ? 1 : 0) - (b_pair_done ? 1 : 0);
            tick();
            cyc++;
        end
        b_pair_done = 1'b0;
        check("run_reach", b_xfers, target);
    endtask

    initial begin
        int   cnt, dones, p1d, first_c, last_c, cyc, extra;
        logic [3:0] sr;
        logic xf;

        // ---- Reset with phase1_ready high and pair_done pulsing
        a_reset = 1'b0; a_phase1_ready = 1'b1; a_pair_ready = 1'b0; a_pair_done = 1'b0;
        b_reset = 1'b0; b_phase1_ready = 1'b1; b_pair_ready = 1'b0; b_pair_done = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            a_pair_done = (i % 2 == 0);
            b_pair_done = (i % 2 == 0);
            tick();
        end
        check("reset_a_outs", {a_pair_valid, a_phase1_done, a_busy, a_err, a_pair}, 20'h0);
        check("reset_b_outs", {b_pair_valid, b_phase1_done, b_busy, b_err, b_pair}, 20'h0);

        a_pair_done = 1'b0; b_pair_done = 1'b0;
        a_phase1_ready = 1'b0; b_phase1_ready = 1'b0;
        a_reset = 1'b1; b_reset = 1'b1;
        tick();
        check("idle_busy", a_busy, 1'b0);

        // ---- Full 3x3x3 sweep with pair_done echoed 4 cycles after each transfer
        a_phase1_ready = 1'b1;
        a_pair_ready   = 1'b1;
        check("valid_not_yet", a_pair_valid, 1'b0);
        tick();
        check("first_valid", a_pair_valid, 1'b1);
        cnt = 0; dones = 0; p1d = 0; first_c = -1; last_c = -1; cyc = 0; sr = '0;
        while (p1d == 0 && cyc < 2000) begin
            if (a_phase1_done) begin
                p1d++;
                check("sweep_xfers", cnt, 378);
                check("sweep_drained", dones, 378);
            end else begin
                xf = a_pair_valid && a_pair_ready;
                if (xf) begin
                    check("sweep_pair", a_pair, exp_pair(cnt, 3, 3, 3));
                    if (first_c < 0) first_c = cyc;
                    last_c = cyc;
                    cnt++;
                end
                a_pair_done = sr[3];
                if (sr[3]) dones++;
                sr = {sr[2:0], xf};
                tick();
                cyc++;
            end
        end
        check("sweep_done_seen", p1d, 1);
        check("one_per_cycle", last_c - first_c, 377);
        a_pair_done = 1'b0;
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_phase1_done) extra++;
        end
        check("single_done_pulse", extra, 0);
        check("wait_low_busy", a_busy, 1'b1);
        a_phase1_ready = 1'b0;
        tick();
        check("idle_after_drop", a_busy, 1'b0);

        // ---- Backpressure on 4x4x4
        b_phase1_ready = 1'b1;
        b_pair_ready   = 1'b0;
        tick();
        check("b_first_valid", b_pair_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {b_pair_valid, b_pair}, {1'b1, exp_pair(0, 4, 4, 4)});
            tick();
        end
        b_pair_ready = 1'b1;
        tick();
        b_pair_ready = 1'b0;
        check("bp_advance", b_pair, exp_pair(1, 4, 4, 4));
        check("nbr_idx1", b_nbr_cell, 6'b00_00_01);
        b_pair_ready = 1'b1;
        tick();
        b_pair_ready = 1'b0;
        check("wrap_neg_x_bp", b_nbr_cell, 6'b00_01_11);
        b_xfers = 2;

        // ---- Throttle: no pair_done, expect stop at 8 in flight
        b_pair_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (b_pair_valid) b_xfers++;
            tick();
        end
        check("throttle_count", b_xfers, 8);
        check("throttle_valid", b_pair_valid, 1'b0);
        b_pair_done = 1'b1;
        tick();
        b_pair_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (b_pair_valid) b_xfers++;
            tick();
        end
        check("one_more_count", b_xfers, 9);
        check("one_more_valid", b_pair_valid, 1'b0);
        b_pair_done = 1'b1;
        tick();
        check("throttle_reopen", b_pair_valid, 1'b1);
        tick();
        b_pair_done = 1'b0;
        check("coincident_unchanged", b_pair_valid, 1'b1);
        tick();
        check("throttle_refull", b_pair_valid, 1'b0);

        // ---- Abort after the 50th transfer
        b_reset = 1'b0;
        tick();
        b_reset = 1'b1;
        b_xfers = 0; b_inflt = 0;
        tick();
        run_b(50);
        b_reset = 1'b0;
        tick();
        check("abort_outs", {b_pair_valid, b_phase1_done, b_busy, b_err, b_pair}, 20'h0);
        b_reset = 1'b1;
        b_xfers = 0; b_inflt = 0;
        tick();
        check("restart_pair", {b_pair_valid, b_pair}, {1'b1, exp_pair(0, 4, 4, 4)});
        run_b(700);

        // ---- pair_done in IDLE sets the sticky error
        b_reset = 1'b0; b_phase1_ready = 1'b0; b_pair_ready = 1'b0;
        tick();
        b_reset = 1'b1;
        tick();
        check("err_clear", b_err, 1'b0);
        b_pair_done = 1'b1;
        tick();
        b_pair_done = 1'b0;
        check("err_set", b_err, 1'b1);
        tick(); tick(); tick();
        check("err_sticky", {b_err, b_busy}, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
